// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU select codes, op-class encoding and datapath width
// Consumed by the issue stage, its forwarding muxes and the downstream ALU.
package alu_pkg;
  localparam int XLEN_DEF = 32;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_OR   = 4'b0100,
    ALU_AND  = 4'b0101,
    ALU_XOR  = 4'b0111,
    ALU_SLL  = 4'b1000,
    ALU_SRL  = 4'b1001,
    ALU_SRA  = 4'b1010,
    ALU_SLT  = 4'b1101,
    ALU_SLTU = 4'b1111
  } alu_sel_e;
  typedef enum logic [2:0] {
    OP_R      = 3'd0,
    OP_I      = 3'd1,
    OP_LUI    = 3'd2,
    OP_AUIPC  = 3'd3,
    OP_LOAD   = 3'd4,
    OP_STORE  = 3'd5,
    OP_BRANCH = 3'd6,
    OP_RSVD   = 3'd7
  } op_class_e;
  function automatic alu_sel_e funct3_sel(input logic [2:0] f3, input logic b5, input logic is_r);
    case (f3)
      3'b000:  return (is_r && b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/alu_fwd_mux.sv
// alu_fwd_mux: selects one source operand from x0, EX/MEM, MEM/WB or the register file
// Ports: addr/rf_data (register-file read), exm_* (EX/MEM result), wb_* (MEM/WB result),
// fwd_data (forwarded operand). Purely combinational.
module alu_fwd_mux import alu_pkg::*; #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [4:0]      addr,
  input  logic [XLEN-1:0] rf_data,
  input  logic            exm_wen,
  input  logic            exm_is_load,
  input  logic [4:0]      exm_rd,
  input  logic [XLEN-1:0] exm_data,
  input  logic            wb_wen,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] fwd_data
);
  logic exm_hit;
  logic wb_hit;
  always_comb begin
    // a load in EX/MEM has no data yet; the hazard logic stalls instead
    exm_hit  = exm_wen && !exm_is_load && exm_rd == addr;
    wb_hit   = wb_wen && wb_rd == addr;
    fwd_data = addr == 5'd0 ? '0 : exm_hit ? exm_data : wb_hit ? wb_data : rf_data;
  end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: forwards operands, decodes ALU select and registers the ALU issue slot
// Ports: in_* decoded instruction with valid/ready, exm_*/wb_* forwarding sources,
// flush kills held and incoming instruction, out_* registered ALU operands with
// valid/ready, stall_cycles saturating count of load-use stall cycles.
module alu_issue_stage import alu_pkg::*; #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op_class,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7_b5,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [4:0]      in_rs1_addr,
  input  logic [4:0]      in_rs2_addr,
  input  logic [4:0]      in_rd,
  input  logic            exm_wen,
  input  logic            exm_is_load,
  input  logic [4:0]      exm_rd,
  input  logic [XLEN-1:0] exm_data,
  input  logic            wb_wen,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [XLEN-1:0] out_store_data,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      out_alu_select,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_op_class,
  output logic [31:0]     stall_cycles
);
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;
  logic [XLEN-1:0] a, b, sd;
  logic [XLEN-1:0] a_d, a_q, b_d, b_q, sd_d, sd_q, pc_d, pc_q;
  logic [3:0]      sel_d, sel_q;
  logic [4:0]      rd, rd_d, rd_q;
  logic [2:0]      cls_d, cls_q;
  logic            valid_d, valid_q;
  logic [31:0]     stall_d, stall_q;
  logic            use_rs1, use_rs2, hazard, capture;
  op_class_e       cls;
  alu_sel_e        sel;

  alu_fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
    .addr(in_rs1_addr), .rf_data(in_rs1_data),
    .exm_wen(exm_wen), .exm_is_load(exm_is_load), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data), .fwd_data(rs1_fwd)
  );
  alu_fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
    .addr(in_rs2_addr), .rf_data(in_rs2_data),
    .exm_wen(exm_wen), .exm_is_load(exm_is_load), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data), .fwd_data(rs2_fwd)
  );

  always_comb begin
    cls     = op_class_e'(in_op_class);
    use_rs1 = cls inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH};
    use_rs2 = cls inside {OP_R, OP_STORE, OP_BRANCH};
    hazard  = in_valid && exm_wen && exm_is_load && exm_rd != 5'd0 &&
              ((use_rs1 && exm_rd == in_rs1_addr) || (use_rs2 && exm_rd == in_rs2_addr));
    // flush drains everything, so the upstream may always hand over its doomed instruction
    in_ready = flush || ((!valid_q || out_ready) && !hazard);
    capture  = in_valid && in_ready && !flush;
    sel = (cls == OP_R || cls == OP_I) ? funct3_sel(in_funct3, in_funct7_b5, cls == OP_R) :
          cls == OP_BRANCH ? (in_funct3[2:1] == 2'b10 ? ALU_SLT :
                              in_funct3[2:1] == 2'b11 ? ALU_SLTU : ALU_SUB) : ALU_ADD;
    a  = (cls == OP_LUI || cls == OP_RSVD) ? '0 : cls == OP_AUIPC ? in_pc : rs1_fwd;
    b  = (cls == OP_R || cls == OP_BRANCH) ? rs2_fwd : cls == OP_RSVD ? '0 : in_imm;
    sd = cls == OP_STORE ? rs2_fwd : '0;
    rd = (cls == OP_BRANCH || cls == OP_RSVD) ? 5'd0 : in_rd;
    a_d     = capture ? a : a_q;
    b_d     = capture ? b : b_q;
    sd_d    = capture ? sd : sd_q;
    pc_d    = capture ? in_pc : pc_q;
    sel_d   = capture ? sel : sel_q;
    rd_d    = capture ? rd : rd_q;
    cls_d   = capture ? in_op_class : cls_q;
    valid_d = flush ? 1'b0 : capture ? 1'b1 : (out_ready ? 1'b0 : valid_q);
    stall_d = (hazard && !flush && stall_q != 32'hFFFF_FFFF) ? stall_q + 32'd1 : stall_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sd_q    <= '0;
      pc_q    <= '0;
      sel_q   <= ALU_ADD;
      rd_q    <= '0;
      cls_q   <= '0;
      valid_q <= 1'b0;
      stall_q <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sd_q    <= sd_d;
      pc_q    <= pc_d;
      sel_q   <= sel_d;
      rd_q    <= rd_d;
      cls_q   <= cls_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_a          = a_q;
  assign out_b          = b_q;
  assign out_store_data = sd_q;
  assign out_pc         = pc_q;
  assign out_alu_select = sel_q;
  assign out_rd         = rd_q;
  assign out_op_class   = cls_q;
  assign stall_cycles   = stall_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed scenarios plus randomized run against an instruction-level model
module tb_alu_issue_stage;
  logic        clk, rst_n;
  logic        in_valid, in_ready, in_funct7_b5;
  logic [2:0]  in_op_class, in_funct3;
  logic [31:0] in_pc, in_imm, in_rs1_data, in_rs2_data;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd;
  logic        exm_wen, exm_is_load, wb_wen, flush, out_valid, out_ready;
  logic [4:0]  exm_rd, wb_rd, out_rd;
  logic [31:0] exm_data, wb_data, out_a, out_b, out_store_data, out_pc, stall_cycles;
  logic [3:0]  out_alu_select;
  logic [2:0]  out_op_class;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_stall = 0;
  logic        ev;
  logic [31:0] ea, eb, esd, epc;
  logic [3:0]  esel;
  logic [4:0]  erd;
  logic [2:0]  ecls;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op_class(in_op_class), .in_funct3(in_funct3), .in_funct7_b5(in_funct7_b5),
    .in_pc(in_pc), .in_imm(in_imm), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd(in_rd),
    .exm_wen(exm_wen), .exm_is_load(exm_is_load), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_store_data(out_store_data), .out_pc(out_pc), .out_alu_select(out_alu_select),
    .out_rd(out_rd), .out_op_class(out_op_class), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] m_fwd(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return 32'd0;
    if (exm_wen && !exm_is_load && exm_rd == a) return exm_data;
    if (wb_wen && wb_rd == a) return wb_data;
    return rf;
  endfunction

  function automatic logic [3:0] m_sel(input logic [2:0] c, input logic [2:0] f, input logic b5);
    logic [3:0] tbl [8];
    tbl = '{4'h0, 4'h8, 4'hD, 4'hF, 4'h7, 4'h9, 4'h4, 4'h5};
    if (c == 3'd6) return f[2] ? (f[1] ? 4'hF : 4'hD) : 4'h1;
    if (c > 3'd1) return 4'h0;
    if (f == 3'd0 && c == 3'd0 && b5) return 4'h1;
    if (f == 3'd5 && b5) return 4'hA;
    return tbl[f];
  endfunction

  function automatic logic m_hazard();
    logic u1, u2;
    u1 = in_op_class inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6};
    u2 = in_op_class inside {3'd0, 3'd5, 3'd6};
    return in_valid && exm_wen && exm_is_load && exm_rd != 5'd0 &&
           ((u1 && exm_rd == in_rs1_addr) || (u2 && exm_rd == in_rs2_addr));
  endfunction

  task automatic m_issue();
    logic [31:0] r1, r2;
    r1 = m_fwd(in_rs1_addr, in_rs1_data);
    r2 = m_fwd(in_rs2_addr, in_rs2_data);
    ea = r1; eb = in_imm; esd = 32'd0; erd = in_rd;
    case (in_op_class)
      3'd0: eb = r2;
      3'd2: ea = 32'd0;
      3'd3: ea = in_pc;
      3'd5: esd = r2;
      3'd6: begin eb = r2; erd = 5'd0; end
      3'd7: begin ea = 32'd0; eb = 32'd0; erd = 5'd0; end
      default: ;
    endcase
    esel = m_sel(in_op_class, in_funct3, in_funct7_b5);
    epc = in_pc; ecls = in_op_class; ev = 1'b1;
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; out_ready = 1; in_op_class = 0; in_funct3 = 0; in_funct7_b5 = 0;
    in_pc = 0; in_imm = 0; in_rs1_data = 0; in_rs2_data = 0; in_rs1_addr = 0; in_rs2_addr = 0;
    in_rd = 0; exm_wen = 0; exm_is_load = 0; exm_rd = 0; exm_data = 0; wb_wen = 0; wb_rd = 0;
    wb_data = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [2:0] c, input logic [2:0] f3, input logic b5,
                           input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] imm, input logic [31:0] pc);
    in_valid = 1; in_op_class = c; in_funct3 = f3; in_funct7_b5 = b5; in_rs1_addr = a1;
    in_rs2_addr = a2; in_rd = rd; in_rs1_data = d1; in_rs2_data = d2; in_imm = imm; in_pc = pc;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    #3;
    checks++;
    if ({out_valid, out_a, out_b, out_store_data, out_pc, out_alu_select, out_rd, out_op_class} !== '0) begin
      errors++; $display("FAIL reset_outputs: got valid=%0b a=%h b=%h sel=%h, want all zero", out_valid, out_a, out_b, out_alu_select);
    end
    tick(); tick();
    checks++;
    if (stall_cycles !== 32'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_held: got stall=%0d valid=%0b, want 0/0", stall_cycles, out_valid);
    end
    rst_n = 1;
    exp_stall = 0;
    tick();
  endtask

  task automatic test_r_sub();
    idle();
    set_instr(3'd0, 3'd0, 1'b1, 5'd1, 5'd2, 5'd4, 32'd20, 32'd5, 32'd0, 32'h40);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rsub_ready: got %0b want 1", in_ready); end
    tick();
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || out_a !== 32'd20 || out_b !== 32'd5 || out_alu_select !== 4'b0001 || out_rd !== 5'd4) begin
      errors++; $display("FAIL rsub_issue: got v=%0b a=%0d b=%0d sel=%b rd=%0d want 1/20/5/0001/4", out_valid, out_a, out_b, out_alu_select, out_rd);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rsub_drain: got valid=%0b want 0", out_valid); end
  endtask

  task automatic test_forwarding();
    idle();
    set_instr(3'd1, 3'd0, 1'b0, 5'd3, 5'd0, 5'd8, 32'h11, 32'h0, 32'h7, 32'h0);
    exm_wen = 1; exm_rd = 3; exm_data = 32'hAA; wb_wen = 1; wb_rd = 3; wb_data = 32'hBB;
    tick();
    checks++;
    if (out_a !== 32'hAA || out_b !== 32'h7) begin errors++; $display("FAIL fwd_exm: got a=%h b=%h want aa/7", out_a, out_b); end
    exm_wen = 0;
    tick();
    checks++;
    if (out_a !== 32'hBB) begin errors++; $display("FAIL fwd_wb: got a=%h want bb", out_a); end
    wb_wen = 0;
    tick();
    checks++;
    if (out_a !== 32'h11) begin errors++; $display("FAIL fwd_rf: got a=%h want 11", out_a); end
    exm_wen = 1; wb_wen = 1; in_rs1_addr = 0;
    tick();
    checks++;
    if (out_a !== 32'h0) begin errors++; $display("FAIL fwd_x0: got a=%h want 0", out_a); end
    idle();
    tick();
  endtask

  task automatic test_load_use();
    idle();
    exm_wen = 1; exm_is_load = 1; exm_rd = 7; exm_data = 32'hDEAD;
    set_instr(3'd0, 3'd0, 1'b0, 5'd1, 5'd7, 5'd4, 32'd1, 32'd5, 32'd0, 32'h0);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_ready1: got %0b want 0", in_ready); end
    tick(); exp_stall++;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || stall_cycles !== exp_stall) begin
      errors++; $display("FAIL lu_cycle1: got rdy=%0b v=%0b stall=%0d want 0/0/%0d", in_ready, out_valid, stall_cycles, exp_stall);
    end
    tick(); exp_stall++;
    checks++;
    if (out_valid !== 1'b0 || stall_cycles !== exp_stall) begin
      errors++; $display("FAIL lu_cycle2: got v=%0b stall=%0d want 0/%0d", out_valid, stall_cycles, exp_stall);
    end
    exm_wen = 0; exm_is_load = 0; wb_wen = 1; wb_rd = 7; wb_data = 32'h77;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_release: got %0b want 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_a !== 32'd1 || out_b !== 32'h77 || stall_cycles !== exp_stall) begin
      errors++; $display("FAIL lu_issue: got v=%0b a=%h b=%h stall=%0d want 1/1/77/%0d", out_valid, out_a, out_b, stall_cycles, exp_stall);
    end
    idle();
    tick();
  endtask

  task automatic test_backpressure();
    idle();
    set_instr(3'd1, 3'd5, 1'b1, 5'd2, 5'd0, 5'd6, 32'h8000_0000, 32'h0, 32'd2, 32'h0);
    tick();
    out_ready = 0;
    set_instr(3'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd9, 32'd4, 32'd0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_a !== 32'h8000_0000 || out_b !== 32'd2 || out_alu_select !== 4'b1010) begin
        errors++; $display("FAIL bp_hold%0d: got rdy=%0b v=%0b a=%h b=%h sel=%b want 0/1/80000000/2/1010", k, in_ready, out_valid, out_a, out_b, out_alu_select);
      end
      if (k < 2) tick();
    end
    out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %0b want 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_a !== 32'd9 || out_b !== 32'd4 || out_alu_select !== 4'b0000) begin
      errors++; $display("FAIL bp_next: got v=%0b a=%0d b=%0d sel=%b want 1/9/4/0000", out_valid, out_a, out_b, out_alu_select);
    end
    idle();
    tick();
  endtask

  task automatic test_auipc_branch();
    idle();
    set_instr(3'd3, 3'd0, 1'b0, 5'd9, 5'd9, 5'd5, 32'h55, 32'h66, 32'h1000, 32'h100);
    tick();
    checks++;
    if (out_a !== 32'h100 || out_b !== 32'h1000 || out_alu_select !== 4'b0000 || out_rd !== 5'd5) begin
      errors++; $display("FAIL auipc: got a=%h b=%h sel=%b rd=%0d want 100/1000/0000/5", out_a, out_b, out_alu_select, out_rd);
    end
    set_instr(3'd6, 3'd6, 1'b0, 5'd1, 5'd2, 5'd9, 32'h10, 32'h20, 32'h8, 32'h104);
    tick();
    checks++;
    if (out_a !== 32'h10 || out_b !== 32'h20 || out_alu_select !== 4'b1111 || out_rd !== 5'd0 || out_pc !== 32'h104) begin
      errors++; $display("FAIL bltu: got a=%h b=%h sel=%b rd=%0d pc=%h want 10/20/1111/0/104", out_a, out_b, out_alu_select, out_rd, out_pc);
    end
    idle();
    tick();
  endtask

  task automatic test_flush_reset();
    idle();
    out_ready = 0;
    set_instr(3'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd11, 32'd22, 32'd0, 32'h0);
    tick();
    set_instr(3'd0, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 32'd33, 32'd44, 32'd0, 32'h0);
    flush = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %0b want 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_kill: got valid=%0b want 0", out_valid); end
    flush = 0; in_valid = 0; out_ready = 1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_nocapture: got valid=%0b want 0", out_valid); end
    exm_wen = 1; exm_is_load = 1; exm_rd = 7;
    set_instr(3'd0, 3'd0, 1'b0, 5'd1, 5'd7, 5'd4, 32'd1, 32'd5, 32'd0, 32'h0);
    tick(); tick();
    exp_stall += 2;
    checks++;
    if (stall_cycles !== exp_stall) begin errors++; $display("FAIL stall_before_rst: got %0d want %0d", stall_cycles, exp_stall); end
    #2 rst_n = 0;
    #1;
    exp_stall = 0;
    checks++;
    if ({out_valid, out_a, out_b, out_store_data, out_pc, out_alu_select, out_rd, out_op_class, stall_cycles} !== '0) begin
      errors++; $display("FAIL async_reset: got v=%0b a=%h b=%h stall=%0d want all zero", out_valid, out_a, out_b, stall_cycles);
    end
    idle();
    #2 rst_n = 1;
    tick();
  endtask

  task automatic test_random();
    logic hz, er;
    idle();
    tick();
    ev = 0;
    for (int i = 0; i < 500; i++) begin
      in_valid = 1'($urandom); flush = ($urandom_range(0, 11) == 0); out_ready = ($urandom_range(0, 3) != 0);
      in_op_class = 3'($urandom); in_funct3 = 3'($urandom); in_funct7_b5 = 1'($urandom);
      in_rs1_addr = 5'($urandom_range(0, 7)); in_rs2_addr = 5'($urandom_range(0, 7)); in_rd = 5'($urandom);
      in_pc = $urandom; in_imm = $urandom; in_rs1_data = $urandom; in_rs2_data = $urandom;
      exm_wen = 1'($urandom); exm_is_load = 1'($urandom); exm_rd = 5'($urandom_range(0, 7)); exm_data = $urandom;
      wb_wen = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
      hz = m_hazard();
      er = flush || ((!ev || out_ready) && !hz);
      #1;
      checks++;
      if (in_ready !== er) begin errors++; $display("FAIL rand_ready[%0d]: got %0b want %0b", i, in_ready, er); end
      if (flush) ev = 0;
      else if (in_valid && er) m_issue();
      else if (out_ready) ev = 0;
      if (hz && !flush && exp_stall != 32'hFFFF_FFFF) exp_stall++;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== ev || stall_cycles !== exp_stall) begin
        errors++; $display("FAIL rand_state[%0d]: got v=%0b stall=%0d want %0b/%0d", i, out_valid, stall_cycles, ev, exp_stall);
      end
      if (ev) begin
        checks++;
        if ({out_a, out_b, out_store_data, out_pc, out_alu_select, out_rd, out_op_class} !== {ea, eb, esd, epc, esel, erd, ecls}) begin
          errors++; $display("FAIL rand_fields[%0d]: got a=%h b=%h sd=%h pc=%h sel=%h rd=%0d c=%0d want %h/%h/%h/%h/%h/%0d/%0d",
                              i, out_a, out_b, out_store_data, out_pc, out_alu_select, out_rd, out_op_class, ea, eb, esd, epc, esel, erd, ecls);
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_r_sub();
    test_forwarding();
    test_load_use();
    test_backpressure();
    test_auipc_branch();
    test_flush_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
